n_bit_addsub_seq: RTL and testbench

Multi-cycle, parametrised add/subtract unit for the ALU datapath. It processes WIDTH-bit operands in CHUNK-bit slices, one slice per clock, through a single slice adder. It supports unsigned and two's-complement modes, an optional sign-magnitude result, and full flags. It generalises the combinational subtractor to add/sub, signed operation, area/latency trade-off and a start/done handshake.

---
 rtl/n_bit_alu_pkg.sv | 15 +
 rtl/n_bit_adder.sv | 14 +
 rtl/n_bit_addsub_seq.sv | 206 ++++++++++++++++++++
 tb/tb_n_bit_addsub_seq.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/n_bit_alu_pkg.sv
// Shared types for the sequential ALU datapath blocks.
// FSM state encoding and add/subtract opcode values.
package n_bit_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    NEG  = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/n_bit_adder.sv
// Plain WIDTH-bit ripple adder with carry-in; carry-out reported on ov_sgn.
module n_bit_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             ov_sgn
);

  assign {ov_sgn, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/n_bit_addsub_seq.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock through a shared slice adder,
// with optional negate pass that turns a negative raw result into its magnitude.
module n_bit_addsub_seq
  import n_bit_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             is_signed,
  input  logic             mag_en,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             sgn,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  generate
    if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("n_bit_addsub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, raw_q, raw_d;
  logic             op_q, op_d, signed_q, signed_d, mag_q, mag_d;
  logic             zacc_q, zacc_d, cout_c_q, cout_c_d;
  logic             sgn_c_q, sgn_c_d, ovf_c_q, ovf_c_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             sgn_q, sgn_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic             done_q, done_d, ready_q, ready_d;

  int               base;
  logic [CHUNK-1:0] sl_x, sl_y, sl_sum;
  logic             sl_co;
  logic             cin_msb, ovf_calc, sgn_calc, accept;

  assign base = int'(idx_q) * CHUNK;

  // ADD feeds the operands; NEG feeds ~raw + 0 with the carry seeded to 1.
  always_comb begin
    sl_x = a_q[base +: CHUNK];
    sl_y = (op_q == OP_SUB) ? ~b_q[base +: CHUNK] : b_q[base +: CHUNK];
    if (state_q == NEG) begin
      sl_x = ~raw_q[base +: CHUNK];
      sl_y = '0;
    end
  end

  n_bit_adder #(.WIDTH(CHUNK)) u_slice (
    .a      (sl_x),
    .b      (sl_y),
    .cin    (carry_q),
    .sum    (sl_sum),
    .ov_sgn (sl_co)
  );

  assign cin_msb  = sl_x[CHUNK-1] ^ sl_y[CHUNK-1] ^ sl_sum[CHUNK-1];
  assign ovf_calc = signed_q ? (cin_msb ^ sl_co) : (op_q ? ~sl_co : sl_co);
  assign sgn_calc = signed_q ? (sl_sum[CHUNK-1] ^ ovf_calc) : (op_q & ~sl_co);
  assign accept   = start && (state_q == IDLE || state_q == FIN);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    raw_d    = raw_q;
    op_d     = op_q;
    signed_d = signed_q;
    mag_d    = mag_q;
    zacc_d   = zacc_q;
    cout_c_d = cout_c_q;
    sgn_c_d  = sgn_c_q;
    ovf_c_d  = ovf_c_q;
    res_d    = res_q;
    sgn_d    = sgn_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    done_d   = (state_q == FIN);

    case (state_q)
      ADD: begin
        raw_d[base +: CHUNK] = sl_sum;
        carry_d = sl_co;
        zacc_d  = zacc_q & (sl_sum == '0);
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          idx_d    = '0;
          cout_c_d = sl_co;
          ovf_c_d  = ovf_calc;
          sgn_c_d  = sgn_calc;
          if (mag_q && sgn_calc) begin
            state_d = NEG;
            carry_d = 1'b1;
          end else begin
            state_d = FIN;
          end
        end
      end
      NEG: begin
        raw_d[base +: CHUNK] = sl_sum;
        carry_d = sl_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = FIN;
        end
      end
      FIN: begin
        res_d   = raw_q;
        sgn_d   = sgn_c_q;
        cout_d  = cout_c_q;
        ovf_d   = ovf_c_q;
        zero_d  = zacc_q;
        state_d = IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      a_d      = a;
      b_d      = b;
      op_d     = op;
      signed_d = is_signed;
      mag_d    = mag_en;
      idx_d    = '0;
      carry_d  = op;
      zacc_d   = 1'b1;
      state_d  = ADD;
    end

    ready_d = (state_d == IDLE) || (state_d == FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      raw_q    <= '0;
      op_q     <= 1'b0;
      signed_q <= 1'b0;
      mag_q    <= 1'b0;
      zacc_q   <= 1'b0;
      cout_c_q <= 1'b0;
      sgn_c_q  <= 1'b0;
      ovf_c_q  <= 1'b0;
      res_q    <= '0;
      sgn_q    <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      raw_q    <= raw_d;
      op_q     <= op_d;
      signed_q <= signed_d;
      mag_q    <= mag_d;
      zacc_q   <= zacc_d;
      cout_c_q <= cout_c_d;
      sgn_c_q  <= sgn_c_d;
      ovf_c_q  <= ovf_c_d;
      res_q    <= res_d;
      sgn_q    <= sgn_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = res_q;
  assign sgn    = sgn_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_n_bit_addsub_seq.sv
// Directed bench for n_bit_addsub_seq at WIDTH=8, CHUNK=4 with hand-computed expectations.
module tb_n_bit_addsub_seq;
  import n_bit_alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       ready, done;
  logic [7:0] a = '0, b = '0, result;
  logic       op = 1'b0, is_signed = 1'b0, mag_en = 1'b0;
  logic       sgn, cout, ovf, zero;
  int         n_chk = 0;
  int         n_fail = 0;
  int         lat;
  logic       seen_done;

  n_bit_addsub_seq #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .a(a), .b(b), .op(op), .is_signed(is_signed), .mag_en(mag_en),
    .done(done), .result(result), .sgn(sgn), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] r, input logic s, c, v, z);
    chk({tag, ".result"}, 32'(result), 32'(r));
    chk({tag, ".sgn"}, 32'(sgn), 32'(s));
    chk({tag, ".cout"}, 32'(cout), 32'(c));
    chk({tag, ".ovf"}, 32'(ovf), 32'(v));
    chk({tag, ".zero"}, 32'(zero), 32'(z));
  endtask

  // Accept one op, scramble the inputs afterwards, return edges from accept to done.
  task automatic run(input logic [7:0] ia, ib, input logic iop, isg, im, output int n);
    @(negedge clk);
    a = ia; b = ib; op = iop; is_signed = isg; mag_en = im; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~ia; b = 8'h5A; op = ~iop; is_signed = ~isg; mag_en = ~im;
    chk("ready_busy", 32'(ready), 32'd0);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.done", 32'(done), 32'd0);
    chk_out("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #20 @(negedge clk) rst = 1'b0;

    run(8'h05, 8'h09, OP_SUB, 1'b0, 1'b1, lat);
    chk("usub_mag.lat", 32'(lat), 32'd5);
    chk_out("usub_mag", 8'h04, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("usub_mag.pulse", 32'(done), 32'd0);
    chk("usub_mag.hold", 32'(result), 32'h04);

    run(8'hF0, 8'h20, OP_ADD, 1'b0, 1'b0, lat);
    chk("uadd.lat", 32'(lat), 32'd3);
    chk_out("uadd", 8'h10, 1'b0, 1'b1, 1'b1, 1'b0);

    run(8'h7F, 8'h01, OP_ADD, 1'b1, 1'b1, lat);
    chk("sadd_ovf.lat", 32'(lat), 32'd3);
    chk_out("sadd_ovf", 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);

    run(8'h80, 8'h80, OP_ADD, 1'b1, 1'b1, lat);
    chk("s_unrep.lat", 32'(lat), 32'd5);
    chk_out("s_unrep", 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);

    // Back-to-back: busy start ignored, start held in FIN accepted.
    @(negedge clk);
    a = 8'h03; b = 8'h03; op = OP_SUB; is_signed = 1'b1; mag_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b.busy_ready", 32'(ready), 32'd0);
    a = 8'h55; b = 8'h11; op = OP_ADD; start = 1'b1;
    @(posedge clk); #1;
    chk("b2b.fin_ready", 32'(ready), 32'd1);
    chk("b2b.fin_done", 32'(done), 32'd0);
    a = 8'h02; b = 8'h01; op = OP_SUB; is_signed = 1'b1; mag_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b.first_done", 32'(done), 32'd1);
    chk_out("b2b.first", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("b2b.second_accepted", 32'(ready), 32'd0);
    lat = 0;
    @(posedge clk); #1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b.second_lat", 32'(lat), 32'd2);
    chk_out("b2b.second", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset one cycle after accept.
    @(negedge clk);
    a = 8'h7F; b = 8'h01; op = OP_ADD; is_signed = 1'b0; mag_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid.ready", 32'(ready), 32'd1);
    chk("rst_mid.done", 32'(done), 32'd0);
    chk_out("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b0;
    seen_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen_done = seen_done | done;
    end
    chk("rst_mid.no_done", 32'(seen_done), 32'd0);

    run(8'h10, 8'h01, OP_ADD, 1'b0, 1'b0, lat);
    chk("post_rst.lat", 32'(lat), 32'd3);
    chk_out("post_rst", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish, expected finish before 50000");
    $fatal(1);
  end

endmodule
